me_mb_scheduler: RTL and testbench

ME_MB_SCHEDULER -- requirements
Module: me_mb_scheduler

---
 rtl/me_mb_scheduler.sv | 250 +++++++++++++++++++++++++
 tb/tb_me_mb_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_mb_scheduler.sv
// me_mb_scheduler
// Walks a frame in raster order, one macroblock at a time. For each macroblock
// it asks the loader to fill the memories, starts the motion-estimation
// controller, captures the best SAD/MV and hands the result to a consumer
// using a valid/ready handshake.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   frame_go, r_cfg     : frame start request and search range (latched at start)
//   load_req / load_ack : loader handshake for macroblock (mb_x, mb_y)
//   me_go, me_r         : ME controller start pulse and latched search range
//   me_done, best_sad,
//   best_mv             : ME completion pulse with its result
//   mb_x, mb_y          : current macroblock coordinates
//   res_valid/res_ready,
//   res_sad/mv/mbx/mby  : result payload handshake
//   busy, frame_done    : activity flag and end-of-frame pulse
//   wd_err              : sticky ME timeout flag (only with ME_WATCHDOG_EN)
//
// Build option: define ME_WATCHDOG_EN to bound the wait for me_done.

module me_mb_scheduler #(
    parameter int unsigned MB_COLS = 4,
    parameter int unsigned MB_ROWS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_go,
    input  logic [1:0]  r_cfg,
    output logic        load_req,
    input  logic        load_ack,
    output logic        me_go,
    output logic [1:0]  me_r,
    input  logic        me_done,
    input  logic [15:0] best_sad,
    input  logic [7:0]  best_mv,
    output logic [7:0]  mb_x,
    output logic [7:0]  mb_y,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_sad,
    output logic [7:0]  res_mv,
    output logic [7:0]  res_mbx,
    output logic [7:0]  res_mby,
    output logic        busy,
    output logic        frame_done
`ifdef ME_WATCHDOG_EN
    ,
    output logic        wd_err
`endif
);

    localparam int unsigned COORD_W = 8;
    localparam int unsigned SAD_W   = 16;
    localparam int unsigned MV_W    = 8;
    localparam int unsigned R_W     = 2;
    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(MB_COLS - 1);
    localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(MB_ROWS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        GO      = 3'd2,
        WAIT_ME = 3'd3,
        RESULT  = 3'd4,
        ADVANCE = 3'd5,
        FDONE   = 3'd6
    } state_t;

    state_t state_q, state_d;

    logic               load_req_q,   load_req_d;
    logic               me_go_q,      me_go_d;
    logic               res_valid_q,  res_valid_d;
    logic               busy_q,       busy_d;
    logic               frame_done_q, frame_done_d;
    logic [R_W-1:0]     me_r_q,       me_r_d;
    logic [COORD_W-1:0] mb_x_q,       mb_x_d;
    logic [COORD_W-1:0] mb_y_q,       mb_y_d;
    logic [SAD_W-1:0]   res_sad_q,    res_sad_d;
    logic [MV_W-1:0]    res_mv_q,     res_mv_d;
    logic [COORD_W-1:0] res_mbx_q,    res_mbx_d;
    logic [COORD_W-1:0] res_mby_q,    res_mby_d;

    logic last_mb_c;
    logic wd_expired_c;

    assign last_mb_c = (mb_x_q == LAST_X) && (mb_y_q == LAST_Y);

`ifdef ME_WATCHDOG_EN
    localparam int unsigned WD_W = 13;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wd_err_q, wd_err_d;

    // Counter sits at zero outside WAIT_ME, so it starts fresh on every entry.
    assign wd_expired_c = (wd_cnt_q == {WD_W{1'b1}});

    always_comb begin
        wd_cnt_d = '0;
        wd_err_d = wd_err_q;
        if (state_q == WAIT_ME) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
        if (state_q == IDLE && frame_go) begin
            wd_err_d = 1'b0;
        end else if (state_q == WAIT_ME && !me_done && wd_expired_c) begin
            wd_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_err_q <= wd_err_d;
        end
    end

    assign wd_err = wd_err_q;
`else
    assign wd_expired_c = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_go) state_d = LOAD;
            LOAD:    if (load_ack) state_d = GO;
            GO:      state_d = WAIT_ME;
            WAIT_ME: if (me_done || wd_expired_c) state_d = RESULT;
            RESULT:  if (res_ready) state_d = ADVANCE;
            ADVANCE: state_d = last_mb_c ? FDONE : LOAD;
            FDONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control outputs are decoded from the next state so they come out of flops
    // aligned with the state they belong to.
    always_comb begin
        load_req_d   = (state_d == LOAD);
        me_go_d      = (state_d == GO);
        res_valid_d  = (state_d == RESULT);
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == FDONE);
    end

    // Datapath: range latch, coordinate walk and result capture.
    always_comb begin
        me_r_d    = me_r_q;
        mb_x_d    = mb_x_q;
        mb_y_d    = mb_y_q;
        res_sad_d = res_sad_q;
        res_mv_d  = res_mv_q;
        res_mbx_d = res_mbx_q;
        res_mby_d = res_mby_q;
        case (state_q)
            IDLE: begin
                if (frame_go) begin
                    me_r_d = r_cfg;
                    mb_x_d = '0;
                    mb_y_d = '0;
                end
            end
            WAIT_ME: begin
                if (me_done) begin
                    res_sad_d = best_sad;
                    res_mv_d  = best_mv;
                    res_mbx_d = mb_x_q;
                    res_mby_d = mb_y_q;
                end else if (wd_expired_c) begin
                    res_sad_d = {SAD_W{1'b1}};
                    res_mv_d  = '0;
                    res_mbx_d = mb_x_q;
                    res_mby_d = mb_y_q;
                end
            end
            ADVANCE: begin
                // Last macroblock parks the coordinates at (0,0) instead of
                // stepping mb_y past the frame.
                if (last_mb_c) begin
                    mb_x_d = '0;
                    mb_y_d = '0;
                end else if (mb_x_q == LAST_X) begin
                    mb_x_d = '0;
                    mb_y_d = mb_y_q + COORD_W'(1);
                end else begin
                    mb_x_d = mb_x_q + COORD_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_req_q   <= 1'b0;
            me_go_q      <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            me_r_q       <= '0;
            mb_x_q       <= '0;
            mb_y_q       <= '0;
            res_sad_q    <= '0;
            res_mv_q     <= '0;
            res_mbx_q    <= '0;
            res_mby_q    <= '0;
        end else begin
            load_req_q   <= load_req_d;
            me_go_q      <= me_go_d;
            res_valid_q  <= res_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            me_r_q       <= me_r_d;
            mb_x_q       <= mb_x_d;
            mb_y_q       <= mb_y_d;
            res_sad_q    <= res_sad_d;
            res_mv_q     <= res_mv_d;
            res_mbx_q    <= res_mbx_d;
            res_mby_q    <= res_mby_d;
        end
    end

    assign load_req   = load_req_q;
    assign me_go      = me_go_q;
    assign res_valid  = res_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign me_r       = me_r_q;
    assign mb_x       = mb_x_q;
    assign mb_y       = mb_y_q;
    assign res_sad    = res_sad_q;
    assign res_mv     = res_mv_q;
    assign res_mbx    = res_mbx_q;
    assign res_mby    = res_mby_q;

endmodule

// File: tb/tb_me_mb_scheduler.sv
// tb_me_mb_scheduler
// Directed bench for me_mb_scheduler on a 2x2 macroblock frame. Inputs are
// driven and outputs sampled 1 time unit after each rising edge.

module tb_me_mb_scheduler;

    logic        clk;
    logic        reset;
    logic        frame_go;
    logic [1:0]  r_cfg;
    logic        load_req;
    logic        load_ack;
    logic        me_go;
    logic [1:0]  me_r;
    logic        me_done;
    logic [15:0] best_sad;
    logic [7:0]  best_mv;
    logic [7:0]  mb_x;
    logic [7:0]  mb_y;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_sad;
    logic [7:0]  res_mv;
    logic [7:0]  res_mbx;
    logic [7:0]  res_mby;
    logic        busy;
    logic        frame_done;
`ifdef ME_WATCHDOG_EN
    logic        wd_err;
`endif

    int n_checks = 0;
    int n_errs   = 0;
    int fd_cnt   = 0;

    me_mb_scheduler #(
        .MB_COLS(2),
        .MB_ROWS(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .frame_go  (frame_go),
        .r_cfg     (r_cfg),
        .load_req  (load_req),
        .load_ack  (load_ack),
        .me_go     (me_go),
        .me_r      (me_r),
        .me_done   (me_done),
        .best_sad  (best_sad),
        .best_mv   (best_mv),
        .mb_x      (mb_x),
        .mb_y      (mb_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sad   (res_sad),
        .res_mv    (res_mv),
        .res_mbx   (res_mbx),
        .res_mby   (res_mby),
        .busy      (busy),
        .frame_done(frame_done)
`ifdef ME_WATCHDOG_EN
        ,
        .wd_err    (wd_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done) fd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string pfx);
        check({pfx, "_busy"},       32'(busy),       32'd0);
        check({pfx, "_load_req"},   32'(load_req),   32'd0);
        check({pfx, "_me_go"},      32'(me_go),      32'd0);
        check({pfx, "_res_valid"},  32'(res_valid),  32'd0);
        check({pfx, "_frame_done"}, 32'(frame_done), 32'd0);
        check({pfx, "_me_r"},       32'(me_r),       32'd0);
        check({pfx, "_mb_x"},       32'(mb_x),       32'd0);
        check({pfx, "_mb_y"},       32'(mb_y),       32'd0);
        check({pfx, "_res_sad"},    32'(res_sad),    32'd0);
        check({pfx, "_res_mv"},     32'(res_mv),     32'd0);
        check({pfx, "_res_mbx"},    32'(res_mbx),    32'd0);
        check({pfx, "_res_mby"},    32'(res_mby),    32'd0);
    endtask

    task automatic wait_load(input string tag);
        for (int i = 0; i < 50 && !load_req; i++) tick();
        check({tag, "_load_req_seen"}, 32'(load_req), 32'd1);
    endtask

    // One macroblock with immediate loader/ME responses; optional result stall.
    task automatic run_mb(input logic [7:0] ex, input logic [7:0] ey,
                          input logic [15:0] sad, input logic [7:0] mv,
                          input int stall);
        wait_load("mb");
        check("mb_x", 32'(mb_x), 32'(ex));
        check("mb_y", 32'(mb_y), 32'(ey));
        load_ack = 1'b1;
        tick();
        load_ack = 1'b0;
        check("me_go_high", 32'(me_go), 32'd1);
        check("load_req_drop", 32'(load_req), 32'd0);
        tick();
        check("me_go_one_cycle", 32'(me_go), 32'd0);
        best_sad = sad;
        best_mv  = mv;
        me_done  = 1'b1;
        tick();
        me_done  = 1'b0;
        best_sad = 16'hDEAD;
        best_mv  = 8'h3C;
        check("res_valid", 32'(res_valid), 32'd1);
        check("res_sad",   32'(res_sad),   32'(sad));
        check("res_mv",    32'(res_mv),    32'(mv));
        check("res_mbx",   32'(res_mbx),   32'(ex));
        check("res_mby",   32'(res_mby),   32'(ey));
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_res_valid", 32'(res_valid), 32'd1);
            check("stall_res_sad",   32'(res_sad),   32'(sad));
            check("stall_res_mbx",   32'(res_mbx),   32'(ex));
            check("stall_load_req",  32'(load_req),  32'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("res_valid_drop", 32'(res_valid), 32'd0);
    endtask

    task automatic run_frame(input logic [1:0] cfg, input int stall0);
        fd_cnt   = 0;
        r_cfg    = cfg;
        frame_go = 1'b1;
        tick();
        frame_go = 1'b0;
        r_cfg    = ~cfg;
        check("frame_busy", 32'(busy), 32'd1);
        check("me_r_latch", 32'(me_r), 32'(cfg));
        run_mb(8'd0, 8'd0, 16'h0010, 8'h11, stall0);
        run_mb(8'd1, 8'd0, 16'h0020, 8'h22, 0);
        run_mb(8'd0, 8'd1, 16'h0030, 8'h33, 0);
        run_mb(8'd1, 8'd1, 16'h1234, 8'hA5, 0);
        check("me_r_hold", 32'(me_r), 32'(cfg));
        tick();
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        check("fdone_busy",       32'(busy),       32'd1);
        check("fdone_load_req",   32'(load_req),   32'd0);
        tick();
        check("frame_done_end", 32'(frame_done), 32'd0);
        check("end_busy",       32'(busy),       32'd0);
        check("end_mb_x",       32'(mb_x),       32'd0);
        check("end_mb_y",       32'(mb_y),       32'd0);
        check("frame_done_cnt", 32'(fd_cnt),     32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        frame_go  = 1'b0;
        r_cfg     = 2'd0;
        load_ack  = 1'b0;
        me_done   = 1'b0;
        best_sad  = 16'h0;
        best_mv   = 8'h0;
        res_ready = 1'b0;
        tick();
        tick();
        check_idle("rst");
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Full 2x2 frame with immediate responses, range code 2.
        run_frame(2'd2, 0);

        // Second frame: stalled result, then stray pulses, then reset mid-frame.
        r_cfg    = 2'd3;
        frame_go = 1'b1;
        tick();
        frame_go = 1'b0;
        run_mb(8'd0, 8'd0, 16'h0040, 8'h44, 20);
        wait_load("stray");
        check("stray_mb_x", 32'(mb_x), 32'd1);
        me_done  = 1'b1;
        frame_go = 1'b1;
        r_cfg    = 2'd0;
        tick();
        me_done  = 1'b0;
        frame_go = 1'b0;
        check("stray_load_hold",  32'(load_req),  32'd1);
        check("stray_no_me_go",   32'(me_go),     32'd0);
        check("stray_no_result",  32'(res_valid), 32'd0);
        check("stray_me_r",       32'(me_r),      32'd3);
        load_ack = 1'b1;
        tick();
        load_ack = 1'b0;
        check("stray_me_go", 32'(me_go), 32'd1);
        tick();
        load_ack = 1'b1;
        frame_go = 1'b1;
        tick();
        load_ack = 1'b0;
        frame_go = 1'b0;
        check("wait_no_result", 32'(res_valid), 32'd0);
        check("wait_no_load",   32'(load_req),  32'd0);
        check("wait_no_me_go",  32'(me_go),     32'd0);
        check("wait_busy",      32'(busy),      32'd1);
        check("wait_mb_x",      32'(mb_x),      32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("midrst");
        tick();
        check("post_rst_load", 32'(load_req), 32'd0);

        // Fresh frame after reset restarts at (0,0).
        run_frame(2'd1, 0);

`ifdef ME_WATCHDOG_EN
        r_cfg    = 2'd0;
        frame_go = 1'b1;
        tick();
        frame_go = 1'b0;
        check("wd_err_clear", 32'(wd_err), 32'd0);
        load_ack = 1'b1;
        tick();
        load_ack = 1'b0;
        tick();
        for (int i = 0; i < 9000 && !res_valid; i++) tick();
        check("wd_res_valid", 32'(res_valid), 32'd1);
        check("wd_res_sad",   32'(res_sad),   32'h0000FFFF);
        check("wd_res_mv",    32'(res_mv),    32'd0);
        check("wd_err_set",   32'(wd_err),    32'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        run_mb(8'd1, 8'd0, 16'h0050, 8'h55, 0);
        check("wd_err_sticky", 32'(wd_err), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("wd_err_reset", 32'(wd_err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
